// File: rtl/cmd_output_arbiter.sv
// Round-robin arbiter merging STP/EVP/EVB {result, status} tokens through a
// small circular queue into the shared result/status output FIFO write ports.
module cmd_output_arbiter #(
  parameter int word_size = 16,
  parameter int fifo_size = 1024,
  parameter int q_depth   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rst_instr,
  input  logic [2:0]               req,
  input  logic [word_size-1:0]     result_stp,
  input  logic [word_size-1:0]     result_evp,
  input  logic [word_size-1:0]     result_evb,
  input  logic [word_size-1:0]     status_stp,
  input  logic [word_size-1:0]     status_evp,
  input  logic [word_size-1:0]     status_evb,
  input  logic [word_size-1:0]     pop_out_fifo_result,
  input  logic [word_size-1:0]     pop_out_fifo_status,
  output logic [2:0]               ack,
  output logic                     en_wr_fifo_result,
  output logic                     en_wr_fifo_status,
  output logic [word_size-1:0]     data_out_result,
  output logic [word_size-1:0]     data_out_status,
  output logic [$clog2(q_depth):0] q_count,
  output logic                     busy
);

  localparam int PW  = $clog2(q_depth);
  localparam int QCW = PW + 1;
  localparam logic [word_size-1:0] FIFO_FULL = word_size'(fifo_size);
  localparam logic [QCW-1:0]       Q_FULL    = QCW'(q_depth);

  typedef enum logic {D_IDLE, D_WRITE} drainState_e;

  drainState_e          r_state, w_nextState;
  logic [2:0]           r_ack;
  logic [1:0]           r_lastGnt;
  logic [PW-1:0]        r_wrPtr, r_rdPtr;
  logic [QCW-1:0]       r_qCount;
  logic [word_size-1:0] r_qResult [q_depth];
  logic [word_size-1:0] r_qStatus [q_depth];
  logic [word_size-1:0] r_dataResult, r_dataStatus;

  logic [2:0]           w_reqMasked;
  logic [1:0]           w_scan0, w_scan1, w_scan2;
  logic [1:0]           w_gntIdx;
  logic                 w_gntValid;
  logic                 w_push, w_pop, w_space;
  logic [word_size-1:0] w_tokResult, w_tokStatus;

  function automatic logic [1:0] nextReq(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // A requester whose ack is currently high is already served; ignore its req.
  assign w_reqMasked = req & ~r_ack;
  assign w_scan0     = nextReq(r_lastGnt);
  assign w_scan1     = nextReq(w_scan0);
  assign w_scan2     = nextReq(w_scan1);

  always_comb begin
    w_gntValid = 1'b0;
    w_gntIdx   = w_scan0;
    if (w_reqMasked[w_scan0]) begin
      w_gntValid = 1'b1;
      w_gntIdx   = w_scan0;
    end else if (w_reqMasked[w_scan1]) begin
      w_gntValid = 1'b1;
      w_gntIdx   = w_scan1;
    end else if (w_reqMasked[w_scan2]) begin
      w_gntValid = 1'b1;
      w_gntIdx   = w_scan2;
    end
  end

  always_comb begin
    w_tokResult = result_evb;
    w_tokStatus = status_evb;
    case (w_gntIdx)
      2'd0: begin
        w_tokResult = result_stp;
        w_tokStatus = status_stp;
      end
      2'd1: begin
        w_tokResult = result_evp;
        w_tokStatus = status_evp;
      end
      default: ;
    endcase
  end

  assign w_space = (pop_out_fifo_result < FIFO_FULL) && (pop_out_fifo_status < FIFO_FULL);
  assign w_push  = w_gntValid && (r_qCount < Q_FULL) && rst_instr;
  assign w_pop   = (r_state == D_IDLE) && (r_qCount != '0) && w_space && rst_instr;

  always_comb begin
    w_nextState       = r_state;
    en_wr_fifo_result = 1'b0;
    en_wr_fifo_status = 1'b0;
    case (r_state)
      D_IDLE:  if (w_pop) w_nextState = D_WRITE;
      D_WRITE: begin
        en_wr_fifo_result = 1'b1;
        en_wr_fifo_status = 1'b1;
        w_nextState       = D_IDLE;
      end
      default: w_nextState = D_IDLE;
    endcase
    if (!rst_instr) w_nextState = D_IDLE;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qResult[r_wrPtr] <= w_tokResult;
      r_qStatus[r_wrPtr] <= w_tokStatus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= D_IDLE;
      r_ack        <= 3'b000;
      r_lastGnt    <= 2'd2;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_qCount     <= '0;
      r_dataResult <= '0;
      r_dataStatus <= '0;
    end else if (!rst_instr) begin
      r_state      <= D_IDLE;
      r_ack        <= 3'b000;
      r_lastGnt    <= 2'd2;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_qCount     <= '0;
      r_dataResult <= '0;
      r_dataStatus <= '0;
    end else begin
      r_state  <= w_nextState;
      r_ack    <= w_push ? (3'b001 << w_gntIdx) : 3'b000;
      r_qCount <= r_qCount + QCW'(w_push) - QCW'(w_pop);
      if (w_push) begin
        r_lastGnt <= w_gntIdx;
        r_wrPtr   <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_dataResult <= r_qResult[r_rdPtr];
        r_dataStatus <= r_qStatus[r_rdPtr];
        r_rdPtr      <= r_rdPtr + 1'b1;
      end
    end
  end

  assign ack             = r_ack;
  assign q_count         = r_qCount;
  assign data_out_result = r_dataResult;
  assign data_out_status = r_dataStatus;
  assign busy            = (r_qCount != '0) || (r_state != D_IDLE);

endmodule

// File: tb/tb_cmd_output_arbiter.sv
// Scoreboard bench for cmd_output_arbiter: directed requests push expected
// {result,status} tokens; a monitor pops and compares on every FIFO write.
module tb_cmd_output_arbiter;

  localparam int W = 16;

  logic           clk, rst, rst_instr;
  logic [2:0]     req;
  logic [W-1:0]   result_stp, result_evp, result_evb;
  logic [W-1:0]   status_stp, status_evp, status_evb;
  logic [W-1:0]   pop_out_fifo_result, pop_out_fifo_status;
  logic [2:0]     ack;
  logic           en_wr_fifo_result, en_wr_fifo_status;
  logic [W-1:0]   data_out_result, data_out_status;
  logic [2:0]     q_count;
  logic           busy;

  int             nChecks, nFails, writeCount, wcBase;
  logic [31:0]    sb[$];
  logic           prevEn;
  logic [2:0]     expAck [3];

  cmd_output_arbiter #(.word_size(16), .fifo_size(1024), .q_depth(4)) dut (
    .clk(clk), .rst(rst), .rst_instr(rst_instr), .req(req),
    .result_stp(result_stp), .result_evp(result_evp), .result_evb(result_evb),
    .status_stp(status_stp), .status_evp(status_evp), .status_evb(status_evb),
    .pop_out_fifo_result(pop_out_fifo_result), .pop_out_fifo_status(pop_out_fifo_status),
    .ack(ack), .en_wr_fifo_result(en_wr_fifo_result), .en_wr_fifo_status(en_wr_fifo_status),
    .data_out_result(data_out_result), .data_out_status(data_out_status),
    .q_count(q_count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Raise req for one requester, hold it until its ack is seen, then drop it.
  task automatic applyStimulus(input int idx, input logic [W-1:0] res, input logic [W-1:0] sts, input int maxWait);
    logic got;
    got = 1'b0;
    case (idx)
      0: begin result_stp = res; status_stp = sts; end
      1: begin result_evp = res; status_evp = sts; end
      default: begin result_evb = res; status_evb = sts; end
    endcase
    req[idx] = 1'b1;
    for (int c = 0; c < maxWait; c++) begin
      tick();
      if (ack[idx]) begin
        got = 1'b1;
        break;
      end
    end
    req[idx] = 1'b0;
    checkOutput($sformatf("ackSeen%0d", idx), 32'(got), 32'd1);
  endtask

  // Every FIFO write must match the oldest outstanding expected token.
  task automatic monitorStep();
    logic        en;
    logic [31:0] exp;
    en = en_wr_fifo_result | en_wr_fifo_status;
    if (rst && en) begin
      checkOutput("enPair", 32'(en_wr_fifo_status), 32'(en_wr_fifo_result));
      checkOutput("writeSpacing", 32'(prevEn), 32'd0);
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpectedWrite: actual=%0h required=none", {data_out_result, data_out_status});
      end else begin
        exp = sb.pop_front();
        checkOutput("writeData", {data_out_result, data_out_status}, exp);
      end
      writeCount++;
    end
    prevEn = rst && en;
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int c = 0; c < maxCycles; c++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    checkOutput("drainQueueEmpty", 32'(sb.size()), 32'd0);
    checkOutput("drainBusy", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    nChecks = 0; nFails = 0; writeCount = 0; prevEn = 1'b0;
    rst = 1'b0; rst_instr = 1'b1; req = 3'b000;
    result_stp = '0; result_evp = '0; result_evb = '0;
    status_stp = '0; status_evp = '0; status_evb = '0;
    pop_out_fifo_result = '0; pop_out_fifo_status = '0;
    expAck = '{3'b001, 3'b010, 3'b100};

    fork
      forever begin
        @(negedge clk);
        monitorStep();
      end
    join_none

    // Reset values while rst is held low.
    tick();
    tick();
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstEn", 32'(en_wr_fifo_result), 32'd0);
    checkOutput("rstQCount", 32'(q_count), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstData", {data_out_result, data_out_status}, 32'd0);
    rst = 1'b1;

    // Single STP token: ack after one edge, write visible after the second.
    sb.push_back({16'h0005, 16'h0000});
    result_stp = 16'h0005; status_stp = 16'h0000; req = 3'b001;
    tick();
    checkOutput("t1Ack", 32'(ack), 32'b001);
    checkOutput("t1QCount", 32'(q_count), 32'd1);
    req = 3'b000;
    tick();
    checkOutput("t1AckDrop", 32'(ack), 32'd0);
    checkOutput("t1En", 32'(en_wr_fifo_result), 32'd1);
    checkOutput("t1QEmpty", 32'(q_count), 32'd0);
    tick();
    checkOutput("t1EnDone", 32'(en_wr_fifo_result), 32'd0);
    checkOutput("t1Idle", 32'(busy), 32'd0);

    // All three at once from fresh priority: STP, EVP, EVB in order.
    doReset();
    sb.push_back({16'h0011, 16'h00A1});
    sb.push_back({16'h0022, 16'h00A2});
    sb.push_back({16'h0033, 16'h00A3});
    result_stp = 16'h0011; status_stp = 16'h00A1;
    result_evp = 16'h0022; status_evp = 16'h00A2;
    result_evb = 16'h0033; status_evb = 16'h00A3;
    req = 3'b111;
    for (int t = 0; t < 3; t++) begin
      tick();
      checkOutput($sformatf("t2Ack%0d", t), 32'(ack), 32'(expAck[t]));
      req = req & ~ack;
    end
    tick();
    checkOutput("t2AckIdle", 32'(ack), 32'd0);
    waitDrain(40);

    // Result FIFO full: queue fills to 4, fifth EVP token waits, then all drain.
    wcBase = writeCount;
    pop_out_fifo_result = 16'd1024;
    for (int k = 0; k < 5; k++) sb.push_back({16'h0100 + 16'(k), 16'h0200 + 16'(k)});
    fork
      begin
        for (int k = 0; k < 5; k++) applyStimulus(1, 16'h0100 + 16'(k), 16'h0200 + 16'(k), 300);
      end
      begin
        repeat (20) tick();
        checkOutput("t3QFull", 32'(q_count), 32'd4);
        checkOutput("t3NoAck", 32'(ack), 32'd0);
        checkOutput("t3NoWrites", 32'(writeCount - wcBase), 32'd0);
        checkOutput("t3Busy", 32'(busy), 32'd1);
        pop_out_fifo_result = 16'd1023;
      end
    join
    waitDrain(60);
    checkOutput("t3Writes", 32'(writeCount - wcBase), 32'd5);

    // Status FIFO full alone still stalls both writes.
    wcBase = writeCount;
    pop_out_fifo_result = 16'd0;
    pop_out_fifo_status = 16'd1024;
    sb.push_back({16'h0301, 16'h0401});
    sb.push_back({16'h0302, 16'h0402});
    applyStimulus(0, 16'h0301, 16'h0401, 20);
    applyStimulus(0, 16'h0302, 16'h0402, 20);
    repeat (10) tick();
    checkOutput("t4NoWrites", 32'(writeCount - wcBase), 32'd0);
    checkOutput("t4QCount", 32'(q_count), 32'd2);
    pop_out_fifo_status = 16'd0;
    waitDrain(40);
    checkOutput("t4Writes", 32'(writeCount - wcBase), 32'd2);

    // Soft clear while writing with three tokens still queued.
    pop_out_fifo_result = 16'd1024;
    sb.push_back({16'h0A00, 16'h0B00});
    for (int k = 0; k < 4; k++) applyStimulus(1, 16'h0A00 + 16'(k), 16'h0B00 + 16'(k), 20);
    checkOutput("t5QFull", 32'(q_count), 32'd4);
    pop_out_fifo_result = 16'd0;
    tick();
    checkOutput("t5QCount3", 32'(q_count), 32'd3);
    checkOutput("t5InWrite", 32'(en_wr_fifo_result), 32'd1);
    rst_instr = 1'b0;
    tick();
    checkOutput("t5ClrQCount", 32'(q_count), 32'd0);
    checkOutput("t5ClrEn", 32'(en_wr_fifo_result | en_wr_fifo_status), 32'd0);
    checkOutput("t5ClrAck", 32'(ack), 32'd0);
    checkOutput("t5ClrBusy", 32'(busy), 32'd0);
    checkOutput("t5ClrData", 32'(data_out_result), 32'd0);
    rst_instr = 1'b1;
    sb.push_back({16'h00C1, 16'h00D1});
    sb.push_back({16'h00C2, 16'h00D2});
    sb.push_back({16'h00C3, 16'h00D3});
    result_stp = 16'h00C1; status_stp = 16'h00D1;
    result_evp = 16'h00C2; status_evp = 16'h00D2;
    result_evb = 16'h00C3; status_evb = 16'h00D3;
    req = 3'b111;
    tick();
    checkOutput("t5StpFirst", 32'(ack), 32'b001);
    req = req & ~ack;
    for (int t = 0; t < 6 && req != 3'b000; t++) begin
      tick();
      req = req & ~ack;
    end
    checkOutput("t5AllAcked", 32'(req), 32'd0);
    waitDrain(40);

    // Async reset in the write cycle clears outputs without a clock edge.
    wcBase = writeCount;
    pop_out_fifo_result = 16'd1024;
    applyStimulus(0, 16'h00E1, 16'h00F1, 20);
    applyStimulus(0, 16'h00E2, 16'h00F2, 20);
    pop_out_fifo_result = 16'd0;
    tick();
    checkOutput("t6InWrite", 32'(en_wr_fifo_result), 32'd1);
    checkOutput("t6HeadData", {data_out_result, data_out_status}, {16'h00E1, 16'h00F1});
    checkOutput("t6QCount", 32'(q_count), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6AsyncEn", 32'(en_wr_fifo_result | en_wr_fifo_status), 32'd0);
    checkOutput("t6AsyncData", {data_out_result, data_out_status}, 32'd0);
    checkOutput("t6AsyncQCount", 32'(q_count), 32'd0);
    checkOutput("t6AsyncBusy", 32'(busy), 32'd0);
    checkOutput("t6AsyncAck", 32'(ack), 32'd0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    checkOutput("t6NoWrites", 32'(writeCount - wcBase), 32'd0);
    checkOutput("finalQueue", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cmd_output_arbiter.md
Name: cmd_output_arbiter

Overview:
- Shares the result/status output FIFO write port between the STP, EVP and EVB command FSMs. Today all three drive result/status directly.
- Accepts one {result, status} token per cycle from requesters via req/ack handshake, round-robin arbitrated.
- Buffers accepted tokens in a small internal queue.
- Drains the queue into the result and status FIFOs with full-based backpressure. Sits between the command FSMs and the output FIFOs inside the firing-state datapath.

Parameters:
- word_size, 16, width of result and status tokens
- fifo_size, 1024, capacity of each output FIFO (population compared against this)
- q_depth, 4, internal queue depth in tokens (power of 2, >= 2)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous active-low reset
- rst_instr  input  1  synchronous active-low soft clear from the RST command
- req  input  3  token request; bit0 STP, bit1 EVP, bit2 EVB; held high until acked
- result_stp / result_evp / result_evb  input  word_size each  result token per requester, stable while req high
- status_stp / status_evp / status_evb  input  word_size each  status token per requester
- pop_out_fifo_result  input  word_size  result FIFO population
- pop_out_fifo_status  input  word_size  status FIFO population
- ack  output  3  one-cycle acceptance pulse, one-hot or zero
- en_wr_fifo_result  output  1  result FIFO write enable
- en_wr_fifo_status  output  1  status FIFO write enable
- data_out_result  output  word_size  result FIFO write data
- data_out_status  output  word_size  status FIFO write data
- q_count  output  log2(q_depth)+1  tokens currently queued
- busy  output  1  high when q_count != 0 or drain state != D_IDLE

Behaviour:
- Reset (rst low, async):
  - All outputs 0; queue empty; rd/wr pointers 0.
  - Round-robin pointer last_gnt = 2, so STP has first priority.
  - Drain FSM in D_IDLE.
- rst_instr low (sync): same clear as reset on the next posedge. Any pending write is dropped and ack is forced 0 that cycle.
- Accept path (registered):
  - At a posedge where req != 0 and q_count < q_depth, grant the first requester set in req, scanning from last_gnt+1 mod 3 upward.
  - On that same edge: push {result_x, status_x} at the write pointer, set ack[x]=1 for exactly the following cycle, update last_gnt = x.
  - Requesters drop req in the cycle ack is seen.
  - The arbiter does not grant the same requester on the cycle its ack is high; req is masked by ack.
  - At most one grant per cycle. When the queue is full, no grant and ack = 0; requesters wait.
- Drain FSM:
  - D_IDLE: if q_count > 0 and pop_out_fifo_result < fifo_size and pop_out_fifo_status < fifo_size, latch the queue head into data_out_result/status, pop it, and go to D_WRITE. Otherwise stay in D_IDLE.
  - D_WRITE: en_wr_fifo_result = en_wr_fifo_status = 1 for this single cycle, data stable; return to D_IDLE.
  - Both FIFOs are always written together. Maximum drain rate is one token per 2 cycles, which allows the population counters one cycle to update.
  - Enables are 0 in D_IDLE. data_out_* hold their last value.
- Queue:
  - Circular, pointers wrap modulo q_depth.
  - Simultaneous push and pop on the same edge leaves q_count unchanged.
  - Pop occurs on the D_IDLE to D_WRITE edge.
  - Tokens leave in acceptance order (FIFO order preserved across requesters).
- Full check: output FIFO full means population == fifo_size. Either FIFO full stalls the drain in D_IDLE; the queue keeps accepting until q_count == q_depth.
- Order invariant: a token accepted at edge t appears on the FIFO write port no earlier than cycle t+2, i.e. accept, then D_IDLE→D_WRITE edge, then write cycle.
- Async reset mid-write (in D_WRITE) deasserts the enables immediately; the token is lost by design.

Test Plan:
- Reset then single STP req, result=16'h0005, status=16'h0000, FIFOs empty -> ack=3'b001 one cycle after req; en_wr both high for exactly one cycle two cycles later with data 0005/0000; q_count returns 0.
- req=3'b111 held, each drops on its ack, distinct results 0x11/0x22/0x33 -> acks in order 001, 010, 100 on consecutive grant cycles; FIFO writes 0x11, 0x22, 0x33 in order, one every 2 cycles.
- pop_out_fifo_result=1024 held, 5 EVP tokens requested -> 4 acks, q_count=4, 5th req held without ack, no writes. Drop population to 1023 -> drain resumes, 5th token acked once q_count<4, all 5 written in order.
- pop_out_fifo_status=1024 only (result FIFO has space) -> no write to either FIFO until status space returns.
- rst_instr low for one cycle with q_count=3 and drain in D_WRITE -> next cycle q_count=0, enables 0, ack 0, busy 0; following STP req gets priority (ack=001).
- Async rst asserted mid-operation -> all outputs 0 immediately, without waiting for a clock edge.
